// File: rtl/phase_detect_acc.sv
// Decision-directed carrier phase detector for the QAM16 loop.
// Sign-polarity or 16QAM slicer error, windowed average, saturated out.
module phase_detect_acc #(
  parameter int DW       = 27,
  parameter int AVG_LOG2 = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [DW-1:0] yi,
  input  logic [DW-1:0] yq,
  input  logic          mode,
  input  logic [DW-2:0] thr,
  output logic [DW-1:0] pd,
  output logic          pd_vld
);

  localparam int EW = DW + 3;
  localparam int AW = EW + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'((2 ** AVG_LOG2) - 1);
  localparam logic signed [AW-1:0] PD_MAX =
    {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] PD_MIN = ~PD_MAX;

  // |x| one bit wider so the most-negative input stays exact
  function automatic logic [DW:0] mag(input logic [DW-1:0] x);
    logic [DW:0] xe;
    xe = {x[DW-1], x};
    return x[DW-1] ? (~xe + 1'b1) : xe;
  endfunction

  // d(a)*x with d in {+-1,+-3}: shift+add, then conditional negate
  function automatic logic [EW-1:0] scale(
    input logic [DW-1:0] x,
    input logic          neg,
    input logic          big
  );
    logic [EW-1:0] ext;
    logic [EW-1:0] m;
    ext = {{3{x[DW-1]}}, x};
    m   = big ? ((ext << 1) + ext) : ext;
    return neg ? (~m + 1'b1) : m;
  endfunction

  logic          s1_vld_q, s1_vld_d;
  logic [DW-1:0] s1_yi_q, s1_yi_d;
  logic [DW-1:0] s1_yq_q, s1_yq_d;
  logic          s1_mode_q, s1_mode_d;
  logic          s1_bi_q, s1_bi_d;
  logic          s1_bq_q, s1_bq_d;

  logic                 err_vld_q, err_vld_d;
  logic signed [EW-1:0] e_q, e_d;
  logic                 restart_q, restart_d;
  logic                 mode_last_q, mode_last_d;

  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        pd_q, pd_d;
  logic                 pd_vld_q, pd_vld_d;

  logic signed [AW-1:0] acc_base;
  logic [CW-1:0]        cnt_base;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] avg;

  always_comb begin
    s1_vld_d  = in_vld;
    s1_yi_d   = s1_yi_q;
    s1_yq_d   = s1_yq_q;
    s1_mode_d = s1_mode_q;
    s1_bi_d   = s1_bi_q;
    s1_bq_d   = s1_bq_q;
    if (in_vld) begin
      s1_yi_d   = yi;
      s1_yq_d   = yq;
      s1_mode_d = mode;
      s1_bi_d   = mode && (mag(yi) >= {2'b00, thr});
      s1_bq_d   = mode && (mag(yq) >= {2'b00, thr});
    end
  end

  always_comb begin
    err_vld_d   = s1_vld_q;
    e_d         = e_q;
    restart_d   = 1'b0;
    mode_last_d = mode_last_q;
    if (s1_vld_q) begin
      e_d = scale(s1_yq_q, s1_yi_q[DW-1], s1_bi_q)
          - scale(s1_yi_q, s1_yq_q[DW-1], s1_bq_q);
      restart_d   = (s1_mode_q != mode_last_q);
      mode_last_d = s1_mode_q;
    end
  end

  always_comb begin
    acc_base = restart_q ? '0 : acc_q;
    cnt_base = restart_q ? '0 : cnt_q;
    sum      = acc_base + AW'(e_q);
    avg      = sum >>> AVG_LOG2;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    pd_d     = pd_q;
    pd_vld_d = 1'b0;
    if (err_vld_q) begin
      if (cnt_base == CNT_MAX) begin
        acc_d    = '0;
        cnt_d    = '0;
        pd_vld_d = 1'b1;
        if (avg > PD_MAX)
          pd_d = PD_MAX[DW-1:0];
        else if (avg < PD_MIN)
          pd_d = PD_MIN[DW-1:0];
        else
          pd_d = avg[DW-1:0];
      end else begin
        acc_d = sum;
        cnt_d = cnt_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld_q    <= 1'b0;
      s1_yi_q     <= '0;
      s1_yq_q     <= '0;
      s1_mode_q   <= 1'b0;
      s1_bi_q     <= 1'b0;
      s1_bq_q     <= 1'b0;
      err_vld_q   <= 1'b0;
      e_q         <= '0;
      restart_q   <= 1'b0;
      mode_last_q <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      pd_q        <= '0;
      pd_vld_q    <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_yi_q     <= s1_yi_d;
      s1_yq_q     <= s1_yq_d;
      s1_mode_q   <= s1_mode_d;
      s1_bi_q     <= s1_bi_d;
      s1_bq_q     <= s1_bq_d;
      err_vld_q   <= err_vld_d;
      e_q         <= e_d;
      restart_q   <= restart_d;
      mode_last_q <= mode_last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      pd_q        <= pd_d;
      pd_vld_q    <= pd_vld_d;
    end
  end

  assign pd     = pd_q;
  assign pd_vld = pd_vld_q;

endmodule

// File: tb/tb_phase_detect_acc.sv
// Directed bench for phase_detect_acc.
// Two instances: per-sample output and 4-sample average.
module tb_phase_detect_acc;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_vld = 1'b0;
  logic [7:0]        yi = '0;
  logic [7:0]        yq = '0;
  logic              mode = 1'b0;
  logic [6:0]        thr = '0;
  logic signed [7:0] pd0, pd2;
  logic              vld0, vld2;

  int errs = 0;
  int checks = 0;
  int n2 = 0;
  int base;

  always #5 clk = ~clk;

  phase_detect_acc #(.DW(8), .AVG_LOG2(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_vld(in_vld),
    .yi(yi), .yq(yq), .mode(mode), .thr(thr),
    .pd(pd0), .pd_vld(vld0)
  );

  phase_detect_acc #(.DW(8), .AVG_LOG2(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_vld(in_vld),
    .yi(yi), .yq(yq), .mode(mode), .thr(thr),
    .pd(pd2), .pd_vld(vld2)
  );

  always @(negedge clk)
    if (vld2) n2++;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int i, input int q,
                      input logic m, input int t);
    yi     = 8'(i);
    yq     = 8'(q);
    mode   = m;
    thr    = 7'(t);
    in_vld = 1'b1;
    tick(1);
    in_vld = 1'b0;
  endtask

  task automatic one(input string tag, input int i, input int q,
                     input logic m, input int t, input int exp);
    send(i, q, m, t);
    tick(1);
    chk({tag, "_early"}, int'(vld0), 0);
    tick(1);
    chk({tag, "_vld"}, int'(vld0), 1);
    chk(tag, int'(pd0), exp);
    tick(1);
    chk({tag, "_pulse"}, int'(vld0), 0);
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    in_vld = 1'b0;
    tick(1);
    chk("rst_pd0", int'(pd0), 0);
    chk("rst_vld0", int'(vld0), 0);
    chk("rst_pd2", int'(pd2), 0);
    chk("rst_vld2", int'(vld2), 0);
    rst = 1'b1;
  endtask

  initial begin
    tick(2);
    do_reset();

    one("m0_pos", 10, 4, 1'b0, 0, -6);
    one("m0_neg", -10, 4, 1'b0, 0, 6);
    one("m0_sat", -128, 0, 1'b0, 0, 127);
    one("m0_nowrap", -128, 127, 1'b0, 0, 1);
    one("m1_big", 30, 5, 1'b1, 20, -15);
    one("m1_negq", 127, -19, 1'b1, 20, 70);
    one("m1_eqthr", 20, 5, 1'b1, 20, -5);

    send(10, 4, 1'b0, 0);
    send(-10, 4, 1'b0, 0);
    send(-128, 0, 1'b0, 0);
    chk("strm0_vld", int'(vld0), 1);
    chk("strm0", int'(pd0), -6);
    tick(1);
    chk("strm1_vld", int'(vld0), 1);
    chk("strm1", int'(pd0), 6);
    tick(1);
    chk("strm2_vld", int'(vld0), 1);
    chk("strm2", int'(pd0), 127);
    tick(1);
    chk("strm_end", int'(vld0), 0);

    do_reset();
    base = n2;
    send(10, 4, 1'b0, 0);
    send(-10, 4, 1'b0, 0);
    tick(2);
    send(10, 4, 1'b0, 0);
    tick(1);
    send(9, 4, 1'b0, 0);
    tick(1);
    chk("avg_early", n2 - base, 0);
    tick(1);
    chk("avg_vld", int'(vld2), 1);
    chk("avg_pd", int'(pd2), -3);
    tick(3);
    chk("avg_once", n2 - base, 1);

    base = n2;
    send(10, 4, 1'b0, 0);
    send(10, 4, 1'b0, 0);
    repeat (4) send(30, 5, 1'b1, 20);
    tick(4);
    chk("msw_once", n2 - base, 1);
    chk("msw_pd", int'(pd2), -15);

    base = n2;
    send(10, 4, 1'b0, 0);
    send(10, 4, 1'b0, 0);
    do_reset();
    repeat (4) send(0, 8, 1'b0, 0);
    tick(4);
    chk("rstw_once", n2 - base, 1);
    chk("rstw_pd", int'(pd2), 8);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/phase_detect_acc.md
# phase_detect_acc

Parametrised decision-directed carrier phase detector for the QAM16 receiver carrier-recovery loop. Takes I/Q samples from the derotator with a sample-valid qualifier and computes a per-sample phase error in one of two runtime-selectable modes: sign-polarity (Costas-style) or 16QAM decision-directed with a programmable slicer threshold. It averages 2^AVG_LOG2 errors per output, saturates to the input width, and presents the result with a one-cycle valid strobe to the loop filter.

## Interface
- DW, 27: signed sample width of yi, yq and pd.
- AVG_LOG2, 0: log2 of samples averaged per output; 0 means one output per sample.
- clk  in  1  system clock (8 MHz in the receiver).
- rst  in  1  reset: synchronous and active-low (clears all state on the clk edge while rst=0).
- in_vld  in  1  qualifies yi/yq for this cycle.
- yi  in  DW  signed in-phase sample.
- yq  in  DW  signed quadrature sample.
- mode  in  1  0 = sign-polarity, 1 = 16QAM decision-directed.
- thr  in  DW-1  unsigned slicer threshold, mode 1 only.
- pd  out  DW  signed averaged phase error, held between strobes.
- pd_vld  out  1  one-cycle strobe, pd updated this cycle.

## Operation
- Sign convention: s(x) = +1 if the MSB is 0 (zero counts as positive), else -1.
- Mode 0 error: e = s(yi)*yq - s(yq)*yi.
- Mode 1 slicer, per axis: d(x) = s(x)*3 if |x| >= thr, else s(x)*1. |x| is computed at DW+1 bits so the most-negative input does not overflow.
- Mode 1 error: e = d(yi)*yq - d(yq)*yi. Use shift+add for the multiply by 3; no multipliers.
- Widths:
  - e is DW+3 bits signed; negation of the most-negative input must be exact.
  - The accumulator is DW+3+AVG_LOG2 bits signed.
- Pipeline:
  - S1 registers yi, yq, mode, the slicer decisions and a valid bit.
  - S2 registers e and err_vld.
  - S3 is the accumulator and output.
- Accumulation:
  - Each cycle err_vld=1 adds e to acc and increments a counter (AVG_LOG2 bits).
  - When the counter is 2^AVG_LOG2-1 and err_vld=1:
    - avg = (acc+e) >>> AVG_LOG2, an arithmetic floor shift.
    - pd <= sat(avg) to [-2^(DW-1), 2^(DW-1)-1].
    - pd_vld <= 1.
    - acc and the counter clear to 0.
- Mode change: when S1's registered mode differs from the mode registered with the previous valid sample, acc and the counter clear before that sample is added, so the window restarts. No output is produced for the discarded partial window.
- Gaps in in_vld stall accumulation only. The pipeline holds no stale valid, and pd holds its value.
- Reset values: pd=0, pd_vld=0, acc=0, counter=0, all pipeline valid bits=0, stored mode=0.
- Reset mid-window discards the partial sum. In-flight samples in S1/S2 are dropped.

## Timing
- Sample with in_vld=1 at edge t: S1 at t+1, S2 at t+2, pd/pd_vld at t+3.
- Latency is 3 cycles from the last sample of a window to pd_vld.
- pd_vld is high for exactly one cycle per window. With AVG_LOG2=0 and in_vld held high, pd_vld is high every cycle.
- Back-to-back windows are supported with no dead cycle: the sample following the window's last one is added to a freshly cleared acc.
- thr is sampled in S1 alongside the data. A thr change takes effect for the next valid sample.
- If rst=0 on edge t, outputs are at reset values after t. The first valid sample after release is accepted on the first edge where rst=1.

## Test plan
- DW=8, AVG_LOG2=0, mode 0:
  - yi=10, yq=4 -> pd=-6 with pd_vld 3 cycles after in_vld.
  - yi=-10, yq=4 -> pd=6.
- DW=8, mode 0, yi=-128, yq=0 -> raw error 128 -> pd saturates to 127. yi=-128, yq=127 -> pd=1, with no overflow wrap.
- DW=8, mode 1, thr=20:
  - yi=30, yq=5 (d_i=+3, d_q=+1) -> pd=-15.
  - yi=127, yq=-19 (d_q=-1) -> pd=70.
  - yi=20, yq=5 (|yi| = thr exactly) -> d_i=+3 -> pd=-5.
- DW=8, AVG_LOG2=2, mode 0: errors -6, 6, -6, -5, with in_vld gaps of 0, 2 and 1 cycles between samples -> one pd_vld, pd=floor(-11/4)=-3, 3 cycles after the fourth sample. No strobe earlier.
- DW=8, AVG_LOG2=2: two samples in mode 0, then mode switched to 1 for four samples -> exactly one pd_vld, carrying the mode-1 four-sample average only.
- rst=0 for one cycle after two samples of a window, then four samples of error 8 -> pd_vld once, pd=8. pd=0 and pd_vld=0 while in reset.
